// File: rtl/decode_hazard_pkg.sv
// Shared encodings for the decode-stage interlock: FSM states and counter sizing.
package decode_hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam int WB_LAT_DEF = 3;

  // A counter must be able to hold WB_LAT itself.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(WB_LAT_DEF);

endpackage

// File: rtl/decode_hazard_ctrl_reg_pend_cnt.sv
// Per-register pending-write countdown: load on issue, hold on freeze, else count to 0.
module reg_pend_cnt
  import decode_hazard_pkg::*;
#(
  parameter int WB_LAT = WB_LAT_DEF,
  parameter int CW     = cnt_width(WB_LAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          freeze_i,
  output logic [CW-1:0] cnt_o,
  output logic          nz_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over freeze/decrement so a WAW re-arms the full latency.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CW'(WB_LAT);
    else if (!freeze_i && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign nz_o  = (cnt_q != '0);

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode interlock: per-register write scoreboard, issue/stall decision, dump drain FSM.
module decode_hazard_ctrl
  import decode_hazard_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int BYPASS = 1,
  parameter int NREG   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [2:0] id_rd1_sel,
  input  logic       id_rd1_use,
  input  logic [2:0] id_rd2_sel,
  input  logic       id_rd2_use,
  input  logic       id_wr_en,
  input  logic [2:0] id_wr_sel,
  input  logic       id_dump,
  input  logic       ex_stall,
  input  logic       flush,
  output logic       issue,
  output logic       stall_id,
  output logic       halt,
  output logic       busy,
  output logic       err
);

  localparam int            CW  = cnt_width(WB_LAT);
  localparam logic [CW-1:0] BYP = CW'(BYPASS);

  logic [NREG-1:0][CW-1:0] cnt;
  logic [NREG-1:0]         nz;
  logic                    haz1, haz2, hazard;
  state_e                  state_q, state_d;
  logic                    err_q, err_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_cnt
      reg_pend_cnt #(.WB_LAT(WB_LAT), .CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load_i   (issue & id_wr_en & (id_wr_sel == 3'(gi))),
        .freeze_i (ex_stall),
        .cnt_o    (cnt[gi]),
        .nz_o     (nz[gi])
      );
    end
  endgenerate

  // With bypass a value of 1 means the write lands this cycle and is forwarded.
  assign haz1   = id_rd1_use & (cnt[id_rd1_sel] > BYP);
  assign haz2   = id_rd2_use & (cnt[id_rd2_sel] > BYP);
  assign hazard = haz1 | haz2;

  assign issue    = id_valid & ~hazard & ~ex_stall & ~flush & (state_q == ST_RUN);
  assign stall_id = (id_valid & ~issue & ~flush) | (state_q != ST_RUN);
  assign busy     = |nz;
  assign halt     = (state_q == ST_HALTED);
  assign err      = err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:    if (issue && id_dump) state_d = ST_DRAIN;
      ST_DRAIN:  if (!busy)            state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    err_d = err_q
          | (issue & id_dump & id_wr_en)
          | (id_valid & (state_q == ST_HALTED));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl; two instances differ only in BYPASS.
module tb_decode_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rd1_use, id_rd2_use, id_wr_en, id_dump, ex_stall, flush;
  logic [2:0] id_rd1_sel, id_rd2_sel, id_wr_sel;
  logic       issue, stall_id, halt, busy, err;
  logic       issue0, stall_id0, halt0, busy0, err0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.WB_LAT(3), .BYPASS(1), .NREG(8)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rd1_sel(id_rd1_sel), .id_rd1_use(id_rd1_use),
    .id_rd2_sel(id_rd2_sel), .id_rd2_use(id_rd2_use),
    .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel), .id_dump(id_dump),
    .ex_stall(ex_stall), .flush(flush),
    .issue(issue), .stall_id(stall_id), .halt(halt), .busy(busy), .err(err)
  );

  decode_hazard_ctrl #(.WB_LAT(3), .BYPASS(0), .NREG(8)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rd1_sel(id_rd1_sel), .id_rd1_use(id_rd1_use),
    .id_rd2_sel(id_rd2_sel), .id_rd2_use(id_rd2_use),
    .id_wr_en(id_wr_en), .id_wr_sel(id_wr_sel), .id_dump(id_dump),
    .ex_stall(ex_stall), .flush(flush),
    .issue(issue0), .stall_id(stall_id0), .halt(halt0), .busy(busy0), .err(err0)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic idle();
    id_valid = 0; id_rd1_use = 0; id_rd2_use = 0; id_wr_en = 0;
    id_dump = 0; ex_stall = 0; flush = 0;
    id_rd1_sel = 0; id_rd2_sel = 0; id_wr_sel = 0;
  endtask

  // advance one clock; inputs are then changed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic wr(input logic [2:0] r);
    idle(); id_valid = 1; id_wr_en = 1; id_wr_sel = r;
  endtask

  task automatic rd1(input logic [2:0] r);
    idle(); id_valid = 1; id_rd1_use = 1; id_rd1_sel = r;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    rst = 0;

    // reset state
    settle();
    chk("rst_issue", issue, 1'b0);
    chk("rst_stall", stall_id, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_stall_nb", stall_id0, 1'b0);

    // RAW on r3: bypass issues cycle 3, no-bypass cycle 4
    wr(3); settle();
    chk("raw_c0_issue", issue, 1'b1);
    chk("raw_c0_issue_nb", issue0, 1'b1);
    tick(); rd1(3); settle();
    chk("raw_c1_stall", stall_id, 1'b1);
    chk("raw_c1_busy", busy, 1'b1);
    chk("raw_c1_stall_nb", stall_id0, 1'b1);
    tick(); settle();
    chk("raw_c2_stall", stall_id, 1'b1);
    chk("raw_c2_issue", issue, 1'b0);
    tick(); settle();
    chk("raw_c3_issue", issue, 1'b1);
    chk("raw_c3_stall", stall_id, 1'b0);
    chk("raw_c3_issue_nb", issue0, 1'b0);
    chk("raw_c3_stall_nb", stall_id0, 1'b1);
    tick(); settle();
    chk("raw_c4_issue_nb", issue0, 1'b1);

    // RAW with ex_stall in cycles 1-2: counter freezes, read issues cycle 5
    do_reset();
    wr(3); settle();
    chk("frz_c0_issue", issue, 1'b1);
    tick(); rd1(3); ex_stall = 1; settle();
    chk("frz_c1_issue", issue, 1'b0);
    chk("frz_c1_stall", stall_id, 1'b1);
    tick(); rd1(3); ex_stall = 1; settle();
    chk("frz_c2_stall", stall_id, 1'b1);
    tick(); rd1(3); settle();
    chk("frz_c3_stall", stall_id, 1'b1);
    tick(); settle();
    chk("frz_c4_issue", issue, 1'b0);
    tick(); settle();
    chk("frz_c5_issue", issue, 1'b1);

    // WAW reload: rewrite r2 when cnt[2]=1
    do_reset();
    wr(2); tick(); idle(); tick(); tick();
    wr(2); settle();
    chk("waw_issue", issue, 1'b1);
    tick(); rd1(2); settle();
    chk("waw_c4_busy", busy, 1'b1);
    chk("waw_c4_stall", stall_id, 1'b1);
    tick(); settle();
    chk("waw_c5_stall", stall_id, 1'b1);
    tick(); settle();
    chk("waw_c6_issue", issue, 1'b1);
    tick(); idle(); settle();
    chk("waw_c7_busy", busy, 1'b0);

    // dump drains r5 then halts; later valid sets err
    do_reset();
    wr(5); tick();
    idle(); id_valid = 1; id_dump = 1; settle();
    chk("dmp_c0_issue", issue, 1'b1);
    tick(); idle(); settle();
    chk("dmp_c1_stall", stall_id, 1'b1);
    chk("dmp_c1_halt", halt, 1'b0);
    tick(); settle();
    chk("dmp_c2_halt", halt, 1'b0);
    tick(); settle();
    chk("dmp_c3_halt", halt, 1'b0);
    chk("dmp_c3_busy", busy, 1'b0);
    tick(); settle();
    chk("dmp_c4_halt", halt, 1'b1);
    chk("dmp_c4_stall", stall_id, 1'b1);
    chk("dmp_c4_err", err, 1'b0);
    tick(); rd1(0); settle();
    chk("dmp_c5_halt", halt, 1'b1);
    chk("dmp_c5_issue", issue, 1'b0);
    chk("dmp_c5_err", err, 1'b0);
    tick(); idle(); settle();
    chk("dmp_c6_err", err, 1'b1);
    tick(); settle();
    chk("dmp_c7_err", err, 1'b1);
    chk("dmp_c7_halt", halt, 1'b1);

    // dump that also writes is a protocol error
    do_reset();
    wr(4); id_dump = 1; settle();
    chk("dwr_issue", issue, 1'b1);
    chk("dwr_c0_err", err, 1'b0);
    tick(); idle(); settle();
    chk("dwr_c1_err", err, 1'b1);
    tick(); tick(); settle();
    chk("dwr_c3_err", err, 1'b1);

    // flush kills the decode write without loading its counter
    do_reset();
    wr(6); tick();
    wr(1); flush = 1; settle();
    chk("fl_issue", issue, 1'b0);
    chk("fl_stall", stall_id, 1'b0);
    tick(); rd1(1); settle();
    chk("fl_r1_issue", issue, 1'b1);
    idle(); id_valid = 1; id_rd2_use = 1; id_rd2_sel = 6; settle();
    chk("fl_r6_stall", stall_id, 1'b1);

    // reset in DRAIN with cnt[1]=2 and err set
    do_reset();
    wr(1); tick();
    wr(0); id_dump = 1; settle();
    chk("rdr_dump_issue", issue, 1'b1);
    tick(); idle(); settle();
    chk("rdr_c2_stall", stall_id, 1'b1);
    chk("rdr_c2_err", err, 1'b1);
    rst = 1; tick(); rst = 0; settle();
    chk("rdr_busy", busy, 1'b0);
    chk("rdr_halt", halt, 1'b0);
    chk("rdr_err", err, 1'b0);
    chk("rdr_stall", stall_id, 1'b0);
    rd1(1); settle();
    chk("rdr_r1_issue", issue, 1'b1);

    tick(); idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
